// File: rtl/icache_refill_ctrl.sv
// L1 icache miss/refill controller: turns a lookup miss into one refill burst,
// streams beats into the data array, forwards the critical word and sweeps valid bits.
module icache_refill_ctrl #(
  parameter  int ADDR_W     = 19,
  parameter  int LINE_WORDS = 8,
  parameter  int NUM_LINES  = 64,
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int TAG_W      = ADDR_W - 2 - OFF_W - IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icache_work_en,
  input  logic                     cfg_line_fill,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ack,
  output logic [31:0]              miss_rdata,
  output logic                     pri_cache_refill_req,
  input  logic                     pri_cache_refill_gnt,
  output logic [ADDR_W-1:0]        pri_cache_refill_addr,
  output logic                     pri_cache_refill_lenth,
  input  logic                     pri_cache_refill_r_valid,
  input  logic [31:0]              pri_cache_refill_r_data,
  output logic                     refill_done,
  output logic                     data_we,
  output logic [IDX_W+OFF_W-1:0]   data_waddr,
  output logic [31:0]              data_wdata,
  output logic                     tag_we,
  output logic [IDX_W-1:0]         tag_widx,
  output logic [TAG_W-1:0]         tag_wdata,
  output logic                     tag_wvalid,
  output logic                     busy
);

  typedef enum logic [2:0] {
    INVAL = 3'd0,
    IDLE  = 3'd1,
    REQ   = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [IDX_W:0]   SWEEP_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   SWEEP_END = (IDX_W+1)'(NUM_LINES);

  state_t            cs_r;
  logic [IDX_W:0]    sweep_cnt_r;
  logic [OFF_W-1:0]  beat_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              line_r;
  logic              pend_r;
  logic              work_en_q_r;
  logic              req_r;
  logic [ADDR_W-1:0] refill_addr_r;
  logic              lenth_r;
  logic              refill_done_r;
  logic              tag_we_r;
  logic [IDX_W-1:0]  tag_widx_r;
  logic [TAG_W-1:0]  tag_wdata_r;
  logic              tag_wvalid_r;

  logic              rise_s;
  logic              accept_s;
  logic              last_s;
  logic [OFF_W-1:0]  off_s;
  logic [OFF_W-1:0]  crit_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              data_we_s;
  logic [IDX_W+OFF_W-1:0] data_waddr_s;
  logic [31:0]       data_wdata_s;
  logic              miss_ack_s;
  logic [31:0]       miss_rdata_s;

  assign rise_s   = icache_work_en & ~work_en_q_r;
  assign off_s    = addr_r[OFF_W+1:2];
  assign idx_s    = addr_r[OFF_W+IDX_W+1:OFF_W+2];
  assign tag_s    = addr_r[ADDR_W-1:ADDR_W-TAG_W];
  assign crit_s   = line_r ? off_s : {OFF_W{1'b0}};
  assign last_s   = line_r ? (beat_cnt_r == BEAT_LAST) : 1'b1;
  // Beats count from the grant cycle itself, so REQ with gnt accepts too
  assign accept_s = pri_cache_refill_r_valid &
                    (((cs_r == REQ) & pri_cache_refill_gnt) | (cs_r == FILL));

  // Same-cycle beat forwarding to the data array and the fetch stage
  always_comb begin
    data_we_s    = 1'b0;
    data_waddr_s = {(IDX_W+OFF_W){1'b0}};
    data_wdata_s = 32'd0;
    miss_ack_s   = 1'b0;
    miss_rdata_s = 32'd0;
    if (accept_s) begin
      data_we_s    = line_r;
      data_waddr_s = line_r ? {idx_s, beat_cnt_r} : {(IDX_W+OFF_W){1'b0}};
      data_wdata_s = line_r ? pri_cache_refill_r_data : 32'd0;
      if (beat_cnt_r == crit_s) begin
        miss_ack_s   = 1'b1;
        miss_rdata_s = pri_cache_refill_r_data;
      end else begin
        miss_ack_s   = 1'b0;
        miss_rdata_s = 32'd0;
      end
    end else begin
      data_we_s = 1'b0;
    end
  end

  // Refill FSM with registered request/tag/done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_r          <= INVAL;
      sweep_cnt_r   <= {(IDX_W+1){1'b0}};
      beat_cnt_r    <= {OFF_W{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      line_r        <= 1'b0;
      pend_r        <= 1'b0;
      work_en_q_r   <= 1'b0;
      req_r         <= 1'b0;
      refill_addr_r <= {ADDR_W{1'b0}};
      lenth_r       <= 1'b0;
      refill_done_r <= 1'b0;
      tag_we_r      <= 1'b0;
      tag_widx_r    <= {IDX_W{1'b0}};
      tag_wdata_r   <= {TAG_W{1'b0}};
      tag_wvalid_r  <= 1'b0;
    end else begin
      work_en_q_r   <= icache_work_en;
      refill_done_r <= 1'b0;
      tag_we_r      <= 1'b0;
      tag_wvalid_r  <= 1'b0;
      case (cs_r)
        INVAL: begin
          if (sweep_cnt_r == SWEEP_END) begin
            cs_r <= IDLE;
          end else begin
            tag_we_r    <= 1'b1;
            tag_widx_r  <= sweep_cnt_r[IDX_W-1:0];
            tag_wdata_r <= {TAG_W{1'b0}};
            sweep_cnt_r <= sweep_cnt_r + SWEEP_ONE;
          end
        end
        IDLE: begin
          if (rise_s) begin
            cs_r        <= INVAL;
            sweep_cnt_r <= {(IDX_W+1){1'b0}};
            pend_r      <= 1'b0;
          end else if (miss_req & icache_work_en) begin
            cs_r          <= REQ;
            addr_r        <= miss_addr;
            line_r        <= cfg_line_fill;
            req_r         <= 1'b1;
            lenth_r       <= cfg_line_fill;
            beat_cnt_r    <= {OFF_W{1'b0}};
            refill_addr_r <= cfg_line_fill ?
                             {miss_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}} : miss_addr;
          end else begin
            cs_r <= IDLE;
          end
        end
        REQ: begin
          pend_r <= pend_r | rise_s;
          if (pri_cache_refill_gnt) begin
            req_r <= 1'b0;
            if (accept_s & last_s) begin
              cs_r          <= DONE;
              refill_done_r <= 1'b1;
              tag_we_r      <= line_r;
              tag_wvalid_r  <= line_r;
              tag_widx_r    <= line_r ? idx_s : tag_widx_r;
              tag_wdata_r   <= line_r ? tag_s : tag_wdata_r;
            end else begin
              cs_r       <= FILL;
              beat_cnt_r <= accept_s ? BEAT_ONE : {OFF_W{1'b0}};
            end
          end else begin
            req_r <= 1'b1;
          end
        end
        FILL: begin
          pend_r <= pend_r | rise_s;
          if (accept_s & last_s) begin
            cs_r          <= DONE;
            refill_done_r <= 1'b1;
            tag_we_r      <= line_r;
            tag_wvalid_r  <= line_r;
            tag_widx_r    <= line_r ? idx_s : tag_widx_r;
            tag_wdata_r   <= line_r ? tag_s : tag_wdata_r;
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        DONE: begin
          // An enable rise seen at any point of the refill restarts the sweep
          if (pend_r | rise_s) begin
            cs_r        <= INVAL;
            sweep_cnt_r <= {(IDX_W+1){1'b0}};
            pend_r      <= 1'b0;
          end else begin
            cs_r <= IDLE;
          end
        end
        default: begin
          cs_r        <= INVAL;
          sweep_cnt_r <= {(IDX_W+1){1'b0}};
          pend_r      <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ack               = miss_ack_s;
  assign miss_rdata             = miss_rdata_s;
  assign data_we                = data_we_s;
  assign data_waddr             = data_waddr_s;
  assign data_wdata             = data_wdata_s;
  assign pri_cache_refill_req   = req_r;
  assign pri_cache_refill_addr  = refill_addr_r;
  assign pri_cache_refill_lenth = lenth_r;
  assign refill_done            = refill_done_r;
  assign tag_we                 = tag_we_r;
  assign tag_widx               = tag_widx_r;
  assign tag_wdata              = tag_wdata_r;
  assign tag_wvalid             = tag_wvalid_r;
  assign busy                   = (cs_r != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a scoreboard of expected array writes,
// critical-word acks and tag writes.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        icache_work_en;
  logic        cfg_line_fill;
  logic        miss_req;
  logic [18:0] miss_addr;
  logic        miss_ack;
  logic [31:0] miss_rdata;
  logic        refill_req;
  logic        gnt;
  logic [18:0] refill_addr;
  logic        lenth;
  logic        r_valid;
  logic [31:0] r_data;
  logic        refill_done;
  logic        data_we;
  logic [8:0]  data_waddr;
  logic [31:0] data_wdata;
  logic        tag_we;
  logic [5:0]  tag_widx;
  logic [7:0]  tag_wdata;
  logic        tag_wvalid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int sweep_exp = 0;
  int done_cnt = 0;
  bit ack_seen = 1'b0;

  logic [40:0] q_data [$];
  logic [31:0] q_ack  [$];
  logic [13:0] q_tag  [$];

  icache_refill_ctrl dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .icache_work_en           (icache_work_en),
    .cfg_line_fill            (cfg_line_fill),
    .miss_req                 (miss_req),
    .miss_addr                (miss_addr),
    .miss_ack                 (miss_ack),
    .miss_rdata               (miss_rdata),
    .pri_cache_refill_req     (refill_req),
    .pri_cache_refill_gnt     (gnt),
    .pri_cache_refill_addr    (refill_addr),
    .pri_cache_refill_lenth   (lenth),
    .pri_cache_refill_r_valid (r_valid),
    .pri_cache_refill_r_data  (r_data),
    .refill_done              (refill_done),
    .data_we                  (data_we),
    .data_waddr               (data_waddr),
    .data_wdata               (data_wdata),
    .tag_we                   (tag_we),
    .tag_widx                 (tag_widx),
    .tag_wdata                (tag_wdata),
    .tag_wvalid               (tag_wvalid),
    .busy                     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Called just after a negedge: sample this cycle's outputs, then advance to the next negedge
  task automatic cycle();
    logic [40:0] ed;
    logic [31:0] ea;
    logic [13:0] et;
    #2;
    if (data_we) begin
      ed = (q_data.size() > 0) ? q_data.pop_front() : 41'bx;
      chk("data_write", {data_waddr, data_wdata}, ed);
    end
    if (miss_ack) begin
      ea = (q_ack.size() > 0) ? q_ack.pop_front() : 32'bx;
      chk("miss_rdata", miss_rdata, ea);
      ack_seen = 1'b1;
    end
    if (tag_we && tag_wvalid) begin
      et = (q_tag.size() > 0) ? q_tag.pop_front() : 14'bx;
      chk("tag_write", {tag_widx, tag_wdata}, et);
    end
    if (tag_we && !tag_wvalid) begin
      chk("sweep_idx", tag_widx, sweep_exp);
      sweep_exp++;
    end
    if (refill_done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      cycle();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic refill(input logic [18:0] a, input logic line, input int gnt_dly,
                        input int gap, input bit toggle, input int abort_k);
    logic [31:0] d [8];
    logic [2:0]  off;
    logic [5:0]  idx;
    logic [7:0]  tg;
    logic [18:0] base;
    logic [2:0]  kk;
    int n;
    int d0;
    n    = line ? 8 : 1;
    off  = a[4:2];
    idx  = a[10:5];
    tg   = a[18:11];
    base = line ? {a[18:5], 5'b00000} : a;
    sweep_exp = 0;
    for (int k = 0; k < n; k++) begin
      d[k] = $urandom;
      kk = k[2:0];
      if (abort_k < 0 || k < abort_k) begin
        if (line) q_data.push_back({idx, kk, d[k]});
        if ((line ? off : 3'd0) == kk) q_ack.push_back(d[k]);
      end
    end
    if (line && abort_k < 0) q_tag.push_back({idx, tg});
    cfg_line_fill = line;
    miss_addr     = a;
    miss_req      = 1'b1;
    ack_seen      = 1'b0;
    cycle();
    for (int i = 0; i < gnt_dly; i++) cycle();
    chk("refill_req", refill_req, 1'b1);
    chk("refill_addr", refill_addr, base);
    chk("refill_lenth", lenth, line);
    gnt = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        r_valid = 1'b0;
        for (int g = 0; g < gap; g++) cycle();
      end
      if (toggle && k == 3) icache_work_en = 1'b0;
      if (toggle && k == 5) icache_work_en = 1'b1;
      if (k == abort_k) begin
        r_valid = 1'b0;
        gnt     = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("abort_tag_we", tag_we, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_req", refill_req, 1'b0);
        chk("abort_queues", q_data.size() + q_ack.size() + q_tag.size(), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        miss_req = 1'b0;
        return;
      end
      r_valid = 1'b1;
      r_data  = d[k];
      cycle();
      gnt = 1'b0;
      if (ack_seen) miss_req = 1'b0;
    end
    r_valid = 1'b0;
    chk("ack_seen", ack_seen, 1'b1);
    d0 = done_cnt;
    cycle();
    chk("done_pulse", done_cnt, d0 + 1);
    cycle();
    chk("done_once", done_cnt, d0 + 1);
    chk("busy_after", busy, toggle);
    chk("queues_empty", q_data.size() + q_ack.size() + q_tag.size(), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    icache_work_en = 1'b1;
    cfg_line_fill  = 1'b1;
    miss_req       = 1'b0;
    miss_addr      = 19'd0;
    gnt            = 1'b0;
    r_valid        = 1'b0;
    r_data         = 32'd0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", refill_req, 1'b0);
    chk("rst_ack", miss_ack, 1'b0);
    chk("rst_done", refill_done, 1'b0);
    chk("rst_data_we", data_we, 1'b0);
    chk("rst_tag_we", tag_we, 1'b0);
    chk("rst_addr", refill_addr, 19'd0);
    chk("rst_busy", busy, 1'b1);
    @(negedge clk);
    rst_n     = 1'b1;
    sweep_exp = 0;
    wait_idle();
    chk("sweep_count", sweep_exp, 64);

    // Line fill, critical word 1, grant after 3 cycles
    refill(19'h00124, 1'b1, 3, 0, 1'b0, -1);
    // Single-word uncached fetch at the top of the address space
    refill(19'h7FFFC, 1'b0, 1, 0, 1'b0, -1);
    // Beats every third cycle, critical word 5
    refill(19'h2D434, 1'b1, 0, 2, 1'b0, -1);
    // Enable dropped then raised mid-fill: refill completes, then a full sweep
    refill(19'h0155C, 1'b1, 2, 0, 1'b1, -1);
    wait_idle();
    chk("sweep_after_en", sweep_exp, 64);
    // Reset asserted on beat 4
    refill(19'h00124, 1'b1, 1, 0, 1'b0, 4);
    wait_idle();
    chk("sweep_after_rst", sweep_exp, 64);
    // Last line after the abort
    refill(19'h7FFE0, 1'b1, 0, 1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
